// File: rtl/regfile_pkg.sv
// Shared types and helpers for the CPU register file and its scoreboard.
// The default word size tracks the core data-path width.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } rf_state_t;

   localparam int DEFAULT_WORD_SIZE = 8;

   function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
      return idx < num_regs;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode reservations and
// cleared by writeback, with bypassed lookups for the two read ports.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int REG_BITS = $clog2(NUM_REGS)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                set_en,
   input  logic [REG_BITS-1:0] set_num,
   input  logic                clr_en,
   input  logic [REG_BITS-1:0] clr_num,
   input  logic                look_ok1,
   input  logic [REG_BITS-1:0] look_num1,
   input  logic                look_ok2,
   input  logic [REG_BITS-1:0] look_num2,
   output logic                look_pend1,
   output logic                look_pend2
);

   logic [NUM_REGS-1:0] pending;

   // Set is applied after clear so a same-cycle reserve beats the write.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pending <= '0;
      end else if (flush) begin
         pending <= '0;
      end else begin
         if (clr_en) pending[clr_num] <= 1'b0;
         if (set_en) pending[set_num] <= 1'b1;
      end
   end

   assign look_pend1 = look_ok1 && pending[look_num1] && !(clr_en && clr_num == look_num1);
   assign look_pend2 = look_ok2 && pending[look_num2] && !(clr_en && clr_num == look_num2);

endmodule

// File: rtl/register_file.sv
// General-purpose register file: two registered read ports with write-through
// bypass, one write port, pending-write scoreboard and a sequential clear sweep.
//
//   state | meaning
//   IDLE  | normal operation: reads, writes, reservations, clear requests
//   CLEAR | zero regs[clr_idx] each cycle; all requests ignored
module register_file
   import regfile_pkg::*;
#(
   parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
   parameter int NUM_REGS  = 8,
   parameter int REG_BITS  = $clog2(NUM_REGS),
   parameter bit ZERO_REG  = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 clear_req,
   output logic                 busy,
   input  logic                 rd_en,
   input  logic [REG_BITS-1:0]  rd_num1,
   input  logic [REG_BITS-1:0]  rd_num2,
   output logic [WORD_SIZE-1:0] rd_data1,
   output logic [WORD_SIZE-1:0] rd_data2,
   output logic                 rd_pending1,
   output logic                 rd_pending2,
   output logic                 rd_valid,
   input  logic                 wr_en,
   input  logic [REG_BITS-1:0]  wr_num,
   input  logic [WORD_SIZE-1:0] wr_data,
   input  logic                 resv_en,
   input  logic [REG_BITS-1:0]  resv_num
);

   localparam logic [REG_BITS-1:0] LAST_IDX = REG_BITS'(NUM_REGS - 1);

   function automatic logic usable(input logic [REG_BITS-1:0] n);
      return idx_in_range(32'(n), NUM_REGS) && !(ZERO_REG && n == '0);
   endfunction

   logic [WORD_SIZE-1:0] regs [NUM_REGS];
   rf_state_t            state_q, state_d;
   logic [REG_BITS-1:0]  clr_idx_q, clr_idx_d;

   logic idle, take_clear, accept;
   logic wr_ok, resv_ok, rd_ok, ok1, ok2;
   logic pend1, pend2;
   logic [WORD_SIZE-1:0] data1, data2;

   assign idle       = (state_q == IDLE);
   assign busy       = (state_q == CLEAR);
   assign take_clear = idle && clear_req;
   assign accept     = idle && !clear_req;
   assign wr_ok      = accept && wr_en && usable(wr_num);
   assign resv_ok    = accept && resv_en && usable(resv_num);
   assign rd_ok      = accept && rd_en;
   assign ok1        = usable(rd_num1);
   assign ok2        = usable(rd_num2);

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               clr_idx_d = '0;
            end
         end
         CLEAR: begin
            if (clr_idx_q == LAST_IDX) begin
               state_d   = IDLE;
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Storage has no direct reset; the sweep that follows reset zeroes it.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         if (busy)       regs[clr_idx_q] <= '0;
         else if (wr_ok) regs[wr_num]    <= wr_data;
      end
   end

   always_comb begin
      data1 = '0;
      data2 = '0;
      if (ok1) data1 = (wr_ok && wr_num == rd_num1) ? wr_data : regs[rd_num1];
      if (ok2) data2 = (wr_ok && wr_num == rd_num2) ? wr_data : regs[rd_num2];
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .REG_BITS (REG_BITS)
   ) u_scoreboard (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush      (take_clear),
      .set_en     (resv_ok),
      .set_num    (resv_num),
      .clr_en     (wr_ok),
      .clr_num    (wr_num),
      .look_ok1   (ok1),
      .look_num1  (rd_num1),
      .look_ok2   (ok2),
      .look_num2  (rd_num2),
      .look_pend1 (pend1),
      .look_pend2 (pend2)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_data1    <= '0;
         rd_data2    <= '0;
         rd_pending1 <= 1'b0;
         rd_pending2 <= 1'b0;
         rd_valid    <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            rd_data1    <= data1;
            rd_data2    <= data2;
            rd_pending1 <= pend1;
            rd_pending2 <= pend2;
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a plain and a ZERO_REG instance share stimulus; a
// behavioural model queues expected outputs per cycle, compared after each edge.
module tb_register_file;

   logic       clock = 1'b0;
   logic       reset_n, clear_req, rd_en, wr_en, resv_en;
   logic [2:0] rd_num1, rd_num2, wr_num, resv_num;
   logic [7:0] wr_data;

   logic       a_busy, a_valid, a_p1, a_p2;
   logic [7:0] a_d1, a_d2;
   logic       z_busy, z_valid, z_p1, z_p2;
   logic [7:0] z_d1, z_d2;

   always #5 clock = ~clock;

   register_file #(.WORD_SIZE(8), .NUM_REGS(8), .ZERO_REG(1'b0)) dut (
      .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(a_busy),
      .rd_en(rd_en), .rd_num1(rd_num1), .rd_num2(rd_num2),
      .rd_data1(a_d1), .rd_data2(a_d2), .rd_pending1(a_p1), .rd_pending2(a_p2),
      .rd_valid(a_valid), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
      .resv_en(resv_en), .resv_num(resv_num)
   );

   register_file #(.WORD_SIZE(8), .NUM_REGS(8), .ZERO_REG(1'b1)) dut_z (
      .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(z_busy),
      .rd_en(rd_en), .rd_num1(rd_num1), .rd_num2(rd_num2),
      .rd_data1(z_d1), .rd_data2(z_d2), .rd_pending1(z_p1), .rd_pending2(z_p2),
      .rd_valid(z_valid), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
      .resv_en(resv_en), .resv_num(resv_num)
   );

   typedef struct packed {
      logic [19:0] o1;
      logic [19:0] o0;
   } exp_t;

   exp_t q[$];
   int   n_err = 0;
   int   n_chk = 0;

   logic [7:0] m_regs [2][8];
   bit         m_pend [2][8];
   logic [7:0] m_d1 [2], m_d2 [2];
   bit         m_p1 [2], m_p2 [2];
   bit         m_v, m_clr;
   int         m_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
      end
   endtask

   function automatic void look(input int k, input logic [2:0] n, input bit wok,
                                output logic [7:0] d, output bit p);
      if (k == 1 && n == 3'd0) begin
         d = 8'h00; p = 1'b0;
      end else if (wok && wr_num == n) begin
         d = wr_data; p = 1'b0;
      end else begin
         d = m_regs[k][n]; p = m_pend[k][n];
      end
   endfunction

   task automatic step();
      exp_t e, got;
      bit   v_n, clr_n, wok, rok;
      int   idx_n;
      v_n = 1'b0; clr_n = m_clr; idx_n = m_idx;
      if (!reset_n) begin
         clr_n = 1'b1; idx_n = 0;
         for (int k = 0; k < 2; k++) begin
            m_d1[k] = 8'h00; m_d2[k] = 8'h00; m_p1[k] = 1'b0; m_p2[k] = 1'b0;
            for (int i = 0; i < 8; i++) m_pend[k][i] = 1'b0;
         end
      end else if (m_clr) begin
         for (int k = 0; k < 2; k++) m_regs[k][m_idx] = 8'h00;
         if (m_idx == 7) begin clr_n = 1'b0; idx_n = 0; end
         else idx_n = m_idx + 1;
      end else if (clear_req) begin
         clr_n = 1'b1; idx_n = 0;
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) m_pend[k][i] = 1'b0;
      end else begin
         v_n = rd_en;
         for (int k = 0; k < 2; k++) begin
            wok = wr_en && !(k == 1 && wr_num == 3'd0);
            rok = resv_en && !(k == 1 && resv_num == 3'd0);
            if (rd_en) begin
               look(k, rd_num1, wok, m_d1[k], m_p1[k]);
               look(k, rd_num2, wok, m_d2[k], m_p2[k]);
            end
            if (wok) begin m_regs[k][wr_num] = wr_data; m_pend[k][wr_num] = 1'b0; end
            if (rok) m_pend[k][resv_num] = 1'b1;
         end
      end
      m_v = v_n; m_clr = clr_n; m_idx = idx_n;
      e.o0 = {m_v, m_clr, m_p1[0], m_p2[0], m_d1[0], m_d2[0]};
      e.o1 = {m_v, m_clr, m_p1[1], m_p2[1], m_d1[1], m_d2[1]};
      q.push_back(e);
      @(posedge clock);
      @(negedge clock);
      got = q.pop_front();
      chk("out", 32'({a_valid, a_busy, a_p1, a_p2, a_d1, a_d2}), 32'(got.o0));
      chk("out_z", 32'({z_valid, z_busy, z_p1, z_p2, z_d1, z_d2}), 32'(got.o1));
   endtask

   task automatic drive(input bit rst_n, input bit clr, input bit re,
                        input logic [2:0] n1, input logic [2:0] n2,
                        input bit we, input logic [2:0] wn, input logic [7:0] wd,
                        input bit rv, input logic [2:0] rn);
      reset_n = rst_n; clear_req = clr; rd_en = re; rd_num1 = n1; rd_num2 = n2;
      wr_en = we; wr_num = wn; wr_data = wd; resv_en = rv; resv_num = rn;
      step();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
   endtask

   initial begin
      m_v = 1'b0; m_clr = 1'b1; m_idx = 0;
      for (int k = 0; k < 2; k++) begin
         m_d1[k] = 8'h00; m_d2[k] = 8'h00; m_p1[k] = 1'b0; m_p2[k] = 1'b0;
         for (int i = 0; i < 8; i++) begin m_regs[k][i] = 8'h00; m_pend[k][i] = 1'b0; end
      end

      drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      idle_cycles(10);
      for (int i = 0; i < 8; i++) drive(1, 0, 1, 3'(i), 3'(7 - i), 0, 0, 8'h00, 0, 0);
      idle_cycles(1);

      drive(1, 0, 0, 0, 0, 1, 3, 8'hA5, 0, 0);
      drive(1, 0, 1, 3, 5, 0, 0, 8'h00, 0, 0);
      drive(1, 0, 1, 2, 2, 1, 2, 8'h3C, 0, 0);

      drive(1, 0, 0, 0, 0, 0, 0, 8'h00, 1, 4);
      drive(1, 0, 1, 4, 3, 0, 0, 8'h00, 0, 0);
      drive(1, 0, 1, 4, 4, 1, 4, 8'h11, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 6, 8'h5A, 1, 6);
      drive(1, 0, 1, 6, 4, 0, 0, 8'h00, 0, 0);

      drive(1, 0, 0, 0, 0, 1, 0, 8'hFF, 1, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0);

      drive(1, 0, 0, 0, 0, 1, 1, 8'h77, 0, 0);
      drive(1, 1, 1, 1, 1, 1, 1, 8'h99, 1, 2);
      for (int i = 0; i < 8; i++) drive(1, 0, 1, 1, 2, 1, 1, 8'hEE, 1, 1);
      drive(1, 0, 1, 1, 6, 0, 0, 8'h00, 0, 0);

      drive(1, 0, 0, 0, 0, 1, 5, 8'h42, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      idle_cycles(3);
      drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      idle_cycles(9);
      drive(1, 0, 1, 5, 1, 0, 0, 8'h00, 0, 0);

      for (int i = 0; i < 200; i++)
         drive(($urandom_range(0, 60) != 0), ($urandom_range(0, 25) == 0),
               1'($urandom), 3'($urandom), 3'($urandom),
               1'($urandom), 3'($urandom), 8'($urandom),
               1'($urandom), 3'($urandom));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
